// File: rtl/atm_session_ctrl.sv
// Clocked ATM session controller: card check, PIN entry with bounded retries,
// amount entry with range check, balance check, dispense and eject/retain.
// Every waiting state carries an inactivity timeout; all outputs are registered.
module atm_session_ctrl #(
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT       = 1000,
  parameter int AMOUNT_W      = 16,
  parameter int MAX_AMOUNT    = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cp,
  input  logic                                 c,
  input  logic                                 sf,
  input  logic                                 qd,
  input  logic [AMOUNT_W-1:0]                  amount,
  input  logic                                 chk_done,
  input  logic                                 chk_ok,
  input  logic                                 rq,
  output logic [3:0]                           state,
  output logic                                 chk_req,
  output logic [1:0]                           chk_sel,
  output logic [AMOUNT_W-1:0]                  amt_q,
  output logic                                 dispense,
  output logic                                 retract,
  output logic                                 eject,
  output logic                                 retain,
  output logic                                 amt_err,
  output logic                                 timeout,
  output logic [$clog2(MAX_PIN_TRIES+1)-1:0]   tries_left
);

  localparam int TW = $clog2(MAX_PIN_TRIES + 1);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CHK_CARD = 4'd1,
    PIN      = 4'd2,
    CHK_PIN  = 4'd3,
    AMT      = 4'd4,
    CHK_BAL  = 4'd5,
    DISPENSE = 4'd6,
    EJECT    = 4'd7,
    RETAIN   = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tries_q, tries_d;
  logic [AMOUNT_W-1:0] amt_d;
  logic                chk_req_d, dispense_d, retract_d, eject_d, retain_d;
  logic                amt_err_d, timeout_d;
  logic [1:0]          chk_sel_d;
  logic                timed, evt, restart, done_ok;

  // Next-state, timeout and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    amt_d      = amt_q;
    amt_err_d  = 1'b0;
    timeout_d  = 1'b0;
    retract_d  = 1'b0;
    timed      = 1'b0;
    evt        = 1'b0;
    restart    = 1'b0;
    // chk_req is high only in the first cycle of a check state, so it doubles
    // as the "ignore chk_done this cycle" marker.
    done_ok    = chk_done && !chk_req;

    case (state_q)
      IDLE: begin
        if (cp) state_d = CHK_CARD;
      end
      CHK_CARD: begin
        timed = 1'b1;
        if (done_ok) begin
          evt = 1'b1;
          if (chk_ok) begin
            state_d = PIN;
            tries_d = TW'(MAX_PIN_TRIES);
          end else begin
            state_d = EJECT;
          end
        end
      end
      PIN: begin
        timed = 1'b1;
        if (c) begin
          evt     = 1'b1;
          state_d = EJECT;
        end else if (sf) begin
          evt     = 1'b1;
          state_d = CHK_PIN;
        end
      end
      CHK_PIN: begin
        timed = 1'b1;
        if (done_ok) begin
          evt = 1'b1;
          if (chk_ok) begin
            state_d = AMT;
          end else begin
            tries_d = tries_q - TW'(1);
            state_d = (tries_d == '0) ? RETAIN : PIN;
          end
        end
      end
      AMT: begin
        timed = 1'b1;
        if (c) begin
          evt     = 1'b1;
          state_d = EJECT;
        end else if (qd) begin
          evt = 1'b1;
          if (amount == '0 || amount > AMOUNT_W'(MAX_AMOUNT)) begin
            amt_err_d = 1'b1;
            restart   = 1'b1;
          end else begin
            amt_d   = amount;
            state_d = CHK_BAL;
          end
        end
      end
      CHK_BAL: begin
        timed = 1'b1;
        if (done_ok) begin
          evt     = 1'b1;
          state_d = chk_ok ? DISPENSE : EJECT;
        end
      end
      DISPENSE: begin
        timed = 1'b1;
        if (rq) begin
          evt     = 1'b1;
          state_d = EJECT;
        end
      end
      EJECT: begin
        if (!cp) state_d = IDLE;
      end
      RETAIN: begin
        if (!cp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timed && !evt && cnt_q == CW'(TIMEOUT - 1)) begin
      state_d   = EJECT;
      timeout_d = 1'b1;
      retract_d = (state_q == DISPENSE);
    end

    // Card pulled mid-session: abandon everything, including a result that
    // arrives in the same cycle.
    if (timed && !cp) begin
      state_d   = IDLE;
      tries_d   = tries_q;
      amt_d     = amt_q;
      amt_err_d = 1'b0;
      timeout_d = 1'b0;
      retract_d = 1'b0;
    end

    if (state_d != state_q || restart) cnt_d = '0;
    else if (timed)                    cnt_d = cnt_q + CW'(1);

    chk_req_d  = (state_d != state_q) &&
                 (state_d == CHK_CARD || state_d == CHK_PIN || state_d == CHK_BAL);
    case (state_d)
      CHK_PIN: chk_sel_d = 2'd1;
      CHK_BAL: chk_sel_d = 2'd2;
      default: chk_sel_d = 2'd0;
    endcase
    dispense_d = (state_d == DISPENSE) && (state_q != DISPENSE);
    eject_d    = (state_d == EJECT);
    retain_d   = (state_d == RETAIN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tries_q  <= TW'(MAX_PIN_TRIES);
      amt_q    <= '0;
      chk_req  <= 1'b0;
      chk_sel  <= 2'd0;
      dispense <= 1'b0;
      retract  <= 1'b0;
      eject    <= 1'b0;
      retain   <= 1'b0;
      amt_err  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      amt_q    <= amt_d;
      chk_req  <= chk_req_d;
      chk_sel  <= chk_sel_d;
      dispense <= dispense_d;
      retract  <= retract_d;
      eject    <= eject_d;
      retain   <= retain_d;
      amt_err  <= amt_err_d;
      timeout  <= timeout_d;
    end
  end

  assign state      = state_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with TIMEOUT shortened to 8.
module tb_atm_session_ctrl;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst, cp, c, sf, qd, chk_done, chk_ok, rq;
  logic [AW-1:0] amount;
  logic [3:0]    state;
  logic          chk_req, dispense, retract, eject, retain, amt_err, timeout;
  logic [1:0]    chk_sel;
  logic [AW-1:0] amt_q;
  logic [1:0]    tries_left;

  int n_chk  = 0;
  int n_pass = 0;

  atm_session_ctrl #(
    .MAX_PIN_TRIES(3), .TIMEOUT(8), .AMOUNT_W(AW), .MAX_AMOUNT(1000)
  ) dut (
    .clk(clk), .rst(rst), .cp(cp), .c(c), .sf(sf), .qd(qd), .amount(amount),
    .chk_done(chk_done), .chk_ok(chk_ok), .rq(rq), .state(state),
    .chk_req(chk_req), .chk_sel(chk_sel), .amt_q(amt_q), .dispense(dispense),
    .retract(retract), .eject(eject), .retain(retain), .amt_err(amt_err),
    .timeout(timeout), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // IDLE -> AMT with card and PIN accepted.
  task automatic go_amt();
    cp = 1'b1; tick();
    tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0; sf = 1'b1; tick();
    sf = 1'b0; tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cp = 0; c = 0; sf = 0; qd = 0; chk_done = 0; chk_ok = 0; rq = 0;
    amount = '0;
    ticks(2);
    rst = 1'b0;
    check_val("rst_state", state, 0);
    check_val("rst_tries", tries_left, 3);
    check_val("rst_amt", amt_q, 0);
    check_val("rst_outs", {chk_req, dispense, retract, eject, retain, amt_err, timeout}, 0);

    // Happy path
    cp = 1'b1; tick();
    check_val("hp_chkcard", state, 1);
    check_val("hp_req0", chk_req, 1);
    check_val("hp_sel0", chk_sel, 0);
    chk_done = 1'b1; chk_ok = 1'b0; tick();
    check_val("hp_done_first_ignored", state, 1);
    check_val("hp_req_one_cycle", chk_req, 0);
    chk_ok = 1'b1; tick();
    check_val("hp_pin", state, 2);
    check_val("hp_tries", tries_left, 3);
    chk_done = 1'b0; sf = 1'b1; tick();
    check_val("hp_chkpin", state, 3);
    check_val("hp_sel1", chk_sel, 1);
    check_val("hp_req1", chk_req, 1);
    sf = 1'b0; tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    check_val("hp_amt", state, 4);
    chk_done = 1'b0; qd = 1'b1; amount = 16'd200; tick();
    check_val("hp_chkbal", state, 5);
    check_val("hp_sel2", chk_sel, 2);
    check_val("hp_amtq", amt_q, 200);
    qd = 1'b0; tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    check_val("hp_dispense_st", state, 6);
    check_val("hp_dispense", dispense, 1);
    chk_done = 1'b0; tick();
    check_val("hp_dispense_once", dispense, 0);
    rq = 1'b1; tick();
    check_val("hp_eject_st", state, 7);
    check_val("hp_eject", eject, 1);
    rq = 1'b0; cp = 1'b0; tick();
    check_val("hp_idle", state, 0);
    check_val("hp_eject_off", eject, 0);

    // PIN retries
    cp = 1'b1; tick(); tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sf = 1'b1; tick();
      sf = 1'b0; tick();
      chk_done = 1'b1; chk_ok = 1'b0; tick();
      chk_done = 1'b0;
      check_val("rt_tries", tries_left, 2 - k);
      check_val("rt_state", state, (k == 2) ? 8 : 2);
    end
    check_val("rt_retain", retain, 1);
    cp = 1'b0; tick();
    check_val("rt_idle", state, 0);
    check_val("rt_retain_off", retain, 0);
    check_val("rt_tries_held", tries_left, 0);

    // Amount range, then chk_done on the expiry cycle of CHK_BAL
    go_amt();
    check_val("ar_amt", state, 4);
    check_val("ar_tries_reload", tries_left, 3);
    qd = 1'b1; amount = 16'd0; tick();
    check_val("ar_err0", amt_err, 1);
    check_val("ar_stay0", state, 4);
    qd = 1'b0; tick();
    check_val("ar_err_pulse", amt_err, 0);
    qd = 1'b1; amount = 16'd1001; tick();
    check_val("ar_err1001", amt_err, 1);
    check_val("ar_stay1001", state, 4);
    qd = 1'b0; tick();
    qd = 1'b1; amount = 16'd1000; tick();
    check_val("ar_ok1000", state, 5);
    check_val("ar_amtq", amt_q, 1000);
    check_val("ar_noerr", amt_err, 0);
    qd = 1'b0;
    ticks(7);
    check_val("to_bal_wait", state, 5);
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    check_val("to_bal_evt_wins", state, 6);
    check_val("to_bal_no_to", timeout, 0);
    chk_done = 1'b0;
    // DISPENSE timeout
    ticks(7);
    check_val("to_disp_wait", state, 6);
    tick();
    check_val("to_disp_eject", state, 7);
    check_val("to_disp_timeout", timeout, 1);
    check_val("to_disp_retract", retract, 1);
    tick();
    check_val("to_disp_pulse", {timeout, retract}, 0);
    cp = 1'b0; tick();

    // PIN timeout
    cp = 1'b1; tick(); tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0;
    ticks(7);
    check_val("to_pin_wait", state, 2);
    tick();
    check_val("to_pin_eject", state, 7);
    check_val("to_pin_timeout", timeout, 1);
    check_val("to_pin_noretract", retract, 0);
    cp = 1'b0; tick();

    // Cancel beats sf in PIN
    cp = 1'b1; tick(); tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0; c = 1'b1; sf = 1'b1; tick();
    check_val("cn_pin_eject", state, 7);
    c = 1'b0; sf = 1'b0; cp = 1'b0; tick();

    // Cancel ignored in CHK_PIN
    cp = 1'b1; tick(); tick();
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    chk_done = 1'b0; sf = 1'b1; tick();
    sf = 1'b0; c = 1'b1; tick();
    check_val("cn_chkpin_hold", state, 3);
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    check_val("cn_chkpin_amt", state, 4);
    c = 1'b0; chk_done = 1'b0;

    // Card pulled in CHK_BAL, late result ignored
    qd = 1'b1; amount = 16'd500; tick();
    qd = 1'b0; cp = 1'b0; tick();
    check_val("ab_idle", state, 0);
    chk_done = 1'b1; chk_ok = 1'b1; tick();
    check_val("ab_late_done", state, 0);
    check_val("ab_no_dispense", dispense, 0);
    chk_done = 1'b0;

    // Reset in AMT
    go_amt();
    check_val("rs_amt", state, 4);
    rst = 1'b1; tick();
    check_val("rs_state", state, 0);
    check_val("rs_amtq", amt_q, 0);
    check_val("rs_outs", {chk_req, chk_sel, dispense, retract, eject, retain, amt_err, timeout}, 0);
    rst = 1'b0; cp = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Clocked, parametrised successor to the combinational ATM control FSM. Sequences a full card session: card check, PIN entry with bounded retries, amount entry with range check, balance check, cash dispense, and card eject or retention. Adds per-state inactivity timeouts and a retry counter. Sits between the keypad/card-reader front end and the shared back-end verification unit, which answers every check request over a single request/done handshake.

## Interface
Parameters:
- MAX_PIN_TRIES, 3: wrong PINs allowed before the card is retained; must be ≥1.
- TIMEOUT, 1000: idle cycles allowed in a waiting state; must be ≥2.
- AMOUNT_W, 16: width of the amount bus.
- MAX_AMOUNT, 1000: largest amount accepted; must be ≤2^AMOUNT_W-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cp  in  1  card present (level).
- c  in  1  cancel key (level, sampled each cycle).
- sf  in  1  PIN-finished strobe.
- qd  in  1  amount-entered strobe.
- amount  in  AMOUNT_W  requested amount; valid only when qd=1.
- chk_done  in  1  back-end result strobe.
- chk_ok  in  1  back-end result; valid only when chk_done=1.
- rq  in  1  cash removed by the customer (strobe).
- state  out  4  current state code.
- chk_req  out  1  one-cycle check request.
- chk_sel  out  2  check type: 0 card, 1 PIN, 2 balance; held for the whole check state.
- amt_q  out  AMOUNT_W  latched amount.
- dispense  out  1  one-cycle dispense command.
- retract  out  1  one-cycle cash-retract command.
- eject  out  1  level; open the card slot.
- retain  out  1  level; swallow the card.
- amt_err  out  1  one-cycle out-of-range amount flag.
- timeout  out  1  one-cycle inactivity-abort flag.
- tries_left  out  $clog2(MAX_PIN_TRIES+1)  remaining PIN attempts.

## Operation
State codes:
- IDLE=0, CHK_CARD=1, PIN=2, CHK_PIN=3, AMT=4, CHK_BAL=5, DISPENSE=6, EJECT=7, RETAIN=8.
- Codes 9–15 are illegal; an illegal code goes to IDLE on the next edge.

Transitions:
- IDLE: cp=1 → CHK_CARD. Cancel is ignored.
- CHK_CARD: on chk_done, chk_ok=1 → PIN and tries_left:=MAX_PIN_TRIES. chk_ok=0 → EJECT.
- PIN: c=1 → EJECT, taking priority over sf. sf=1 → CHK_PIN.
- CHK_PIN: on chk_done, chk_ok=1 → AMT. chk_ok=0 → decrement tries_left; if the new value is 0 → RETAIN, else → PIN.
- AMT: c=1 → EJECT, taking priority over qd. On qd=1:
  - amount=0 or amount>MAX_AMOUNT → stay in AMT, pulse amt_err, restart the timeout counter.
  - otherwise → latch amt_q:=amount and go to CHK_BAL.
- CHK_BAL: on chk_done, chk_ok=1 → DISPENSE. chk_ok=0 → EJECT.
- DISPENSE: rq=1 → EJECT.
- EJECT: eject=1; cp=0 → IDLE.
- RETAIN: retain=1; cp=0 → IDLE.

Check states:
- Cancel is ignored in CHK_CARD, CHK_PIN and CHK_BAL; the pending check always completes.
- chk_sel is driven for the whole check state.

Timeout:
- One counter, cleared on every state change. It counts in CHK_CARD, PIN, CHK_PIN, AMT, CHK_BAL and DISPENSE.
- When the counter reaches TIMEOUT-1 with no qualifying event that cycle, the next state is EJECT and timeout pulses.
- A timeout in DISPENSE also pulses retract.
- An event in the same cycle as expiry (chk_done, sf, qd, rq, c) wins; no timeout is raised.

cp dropping:
- In any state other than IDLE, EJECT and RETAIN, cp=0 → IDLE.
- Outstanding check results are then discarded.

## Timing
Reset and registering:
- All outputs are registered.
- After rst: state=IDLE, tries_left=MAX_PIN_TRIES, amt_q=0, and every other output 0.
- rst asserted mid-session aborts on the next edge with no dispense, eject or retain pulse.

Handshake:
- Transitions take effect on the edge after the qualifying input is sampled.
- chk_req is high exactly in the first cycle of each CHK_* state.
- chk_done is ignored in that first cycle and honoured from the second cycle on.
- Fastest check: req at cycle N, done sampled at N+1, next state at N+2.

Output pulses:
- dispense is high in the first cycle of DISPENSE only.
- amt_err, timeout and retract are high for the single cycle after the triggering edge.
- eject and retain are levels, equal to (state==EJECT) and (state==RETAIN).

tries_left:
- Updates on the same edge as the CHK_PIN exit.
- It is held, not reloaded, on return to IDLE.

## Test plan
- Happy path, defaults: cp=1; card ok; sf; PIN ok; qd with amount=200; balance ok; rq; cp=0 → states 0,1,2,3,4,5,6,7,0. One chk_req per check with chk_sel 0/1/2. dispense one cycle with amt_q=200. eject high in EJECT.
- PIN retries: three PIN checks with chk_ok=0 → tries_left 3→2→1→0, states PIN,PIN,RETAIN, retain=1; cp=0 → IDLE.
- Amount range: qd with 0, then 1001 → two amt_err pulses, state stays 4. qd with 1000 → CHK_BAL, amt_q=1000.
- Timeouts with TIMEOUT=8: no sf in PIN for 8 cycles → EJECT with a timeout pulse. A separate run with no rq in DISPENSE → EJECT with retract and timeout pulses. chk_done on the expiry cycle in CHK_BAL → DISPENSE, no timeout.
- Cancel priority: c and sf together in PIN → EJECT. c during CHK_PIN is ignored; chk_ok=1 → AMT.
- Abort paths: cp=0 during CHK_BAL → IDLE; a later chk_done is ignored. rst asserted in AMT → IDLE with all outputs 0 next cycle.
